// File: rtl/regfile_hw_gen2.sv
// Register file with one synchronous write port, two combinational read ports, optional
// write-to-read bypass and two hardware-updated registers (Galois LFSR and cycle counter).
module regfile_hw_gen2 #(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       ADDR_W    = 5,
    parameter bit                BYPASS    = 1'b1,
    parameter int unsigned       LFSR_IDX  = 8,
    parameter logic [DATA_W-1:0] LFSR_SEED = DATA_W'(1),
    parameter logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(32'h8020_0003),
    parameter int unsigned       CYC_IDX   = 9
) (
    input  logic              clock,
    input  logic              ctrl_reset,
    input  logic              ctrl_writeEnable,
    input  logic [ADDR_W-1:0] ctrl_writeReg,
    input  logic [DATA_W-1:0] data_writeReg,
    input  logic [ADDR_W-1:0] ctrl_readRegA,
    input  logic [ADDR_W-1:0] ctrl_readRegB,
    input  logic              ctrl_lfsrEnable,
    input  logic              ctrl_cntEnable,
    output logic [DATA_W-1:0] data_readRegA,
    output logic [DATA_W-1:0] data_readRegB
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam bit                LFSR_ON   = (LFSR_IDX != 0);
    localparam bit                CYC_ON    = (CYC_IDX != 0);
    localparam logic [ADDR_W-1:0] LFSR_ADDR = ADDR_W'(LFSR_IDX);
    localparam logic [ADDR_W-1:0] CYC_ADDR  = ADDR_W'(CYC_IDX);
    localparam logic [DATA_W-1:0] ONE       = DATA_W'(1);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DATA_W-1:0] lfsr_cur;
    logic [DATA_W-1:0] lfsr_next;
    logic [DATA_W-1:0] wr_fwd;
    logic              bypass_a;
    logic              bypass_b;

    // A zero write to the LFSR loads the seed so the lock-up state can never be stored.
    always_comb begin
        wr_fwd = data_writeReg;
        if (LFSR_ON && (ctrl_writeReg == LFSR_ADDR) && (data_writeReg == '0)) begin
            wr_fwd = LFSR_SEED;
        end
    end

    always_comb begin
        lfsr_cur  = regs_q[LFSR_ADDR];
        lfsr_next = (lfsr_cur >> 1) ^ (lfsr_cur[0] ? LFSR_TAPS : '0);
    end

    // Software write is applied last so it overrides an LFSR step or counter increment.
    always_comb begin
        regs_d = regs_q;
        if (LFSR_ON && ctrl_lfsrEnable) begin
            regs_d[LFSR_ADDR] = lfsr_next;
        end
        if (CYC_ON && ctrl_cntEnable) begin
            regs_d[CYC_ADDR] = regs_q[CYC_ADDR] + ONE;
        end
        if (ctrl_writeEnable) begin
            regs_d[ctrl_writeReg] = wr_fwd;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            if (LFSR_ON) begin
                regs_q[LFSR_ADDR] <= LFSR_SEED;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        bypass_a = BYPASS && ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegA);
        bypass_b = BYPASS && ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegB);
    end

    always_comb begin
        if (ctrl_readRegA == '0) begin
            data_readRegA = '0;
        end else if (bypass_a) begin
            data_readRegA = wr_fwd;
        end else begin
            data_readRegA = regs_q[ctrl_readRegA];
        end
    end

    always_comb begin
        if (ctrl_readRegB == '0) begin
            data_readRegB = '0;
        end else if (bypass_b) begin
            data_readRegB = wr_fwd;
        end else begin
            data_readRegB = regs_q[ctrl_readRegB];
        end
    end

endmodule

// File: doc/regfile_hw_gen2.md
Name: regfile_hw_gen2

Overview:
- Parametrised successor of the 32x32 register file in the CPU datapath.
- Provides one synchronous write port and two combinational read ports, with register 0 hard-wired to zero.
- Adds optional write-to-read bypass.
- Adds two hardware-updated registers: a free-running Galois LFSR (game randomness) and a free-running cycle counter. Software can read both and reload both through the normal write port.

Parameters:
- DATA_W, 32, register width in bits (>=2).
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers.
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching reads; 0 = reads show stored value only.
- LFSR_IDX, 8, index of the LFSR register; 0 = feature disabled.
- LFSR_SEED, 1, value loaded into the LFSR at reset, and on any software write of zero to it.
- LFSR_TAPS, 32'h80200003, Galois feedback mask (DATA_W bits).
- CYC_IDX, 9, index of the cycle-counter register; 0 = feature disabled. Must differ from LFSR_IDX unless both are 0.

Ports:
- clock  in  1  sole clock, rising edge.
- ctrl_reset  in  1  synchronous active-high reset.
- ctrl_writeEnable  in  1  write strobe.
- ctrl_writeReg  in  ADDR_W  write address.
- data_writeReg  in  DATA_W  write data.
- ctrl_readRegA  in  ADDR_W  read address A.
- ctrl_readRegB  in  ADDR_W  read address B.
- ctrl_lfsrEnable  in  1  LFSR advances on a cycle when this is 1.
- ctrl_cntEnable  in  1  counter increments on a cycle when this is 1.
- data_readRegA  out  DATA_W  read data A (combinational).
- data_readRegB  out  DATA_W  read data B (combinational).

Behaviour:
- Reset:
  - Sampled only on a rising clock edge; it is synchronous and active-high.
  - All registers clear to 0, except the LFSR register, which loads LFSR_SEED.
  - Reset has priority over writes, LFSR steps and counter increments in the same cycle.
  - Because reads are combinational, reset values are visible from the cycle after the reset edge.
- Write:
  - On a rising edge with ctrl_writeEnable=1 and ctrl_writeReg!=0, reg[ctrl_writeReg] <= data_writeReg.
  - Writes to index 0 are discarded.
- Read:
  - data_readRegX = 0 if addr==0.
  - Otherwise, if BYPASS=1 and ctrl_writeEnable=1 and ctrl_writeReg==addr, the output is data_writeReg. For the LFSR index, a zero write forwards LFSR_SEED instead.
  - Otherwise the output is reg[addr].
  - Both ports are independent; reading the same address on A and B is legal.
- LFSR register (active only when LFSR_IDX!=0):
  - Each edge with ctrl_lfsrEnable=1: q <= (q>>1) ^ (q[0] ? LFSR_TAPS : 0).
  - Software write has priority over the step. A nonzero value loads exactly; zero loads LFSR_SEED, so the all-zero lock-up state is unreachable.
  - Stepping resumes on the following edge.
- Cycle counter (active only when CYC_IDX!=0):
  - Each edge with ctrl_cntEnable=1: q <= q+1, modulo 2**DATA_W.
  - All-ones wraps to 0 with no flag.
  - Software write has priority and loads exactly; incrementing resumes the next edge.
- All other indices are plain storage registers with no autonomous update.
- Write, read, LFSR step and counter increment may all occur in one cycle with no interaction beyond the priorities above.
- Disabled-feature indices behave as ordinary registers.
- Latency:
  - Write to storage visible on reads from the next cycle.
  - Bypass path is 0 cycles.
  - LFSR/counter update visible the cycle after the edge.

Test Plan:
- Reset, then read all 32 indices on A and B -> all 0 except idx 8 = 0x00000001; write idx 0 = 0xFFFFFFFF -> idx 0 reads 0.
- Write idx 5 = 0xDEADBEEF with readRegA=5 in the same cycle, BYPASS=1 -> A=0xDEADBEEF that cycle and after; with BYPASS=0 -> A=0 that cycle, 0xDEADBEEF next.
- Post-reset, ctrl_lfsrEnable=1 for 2 edges -> idx 8 reads 0x80200003, then 0xC0300002; write 0 to idx 8 -> next cycle reads 0x00000001.
- ctrl_cntEnable=1 for 10 edges -> idx 9 = 10; write 0xFFFFFFFE with cntEnable=1 -> reads 0xFFFFFFFE, then 0xFFFFFFFF, then 0x00000000.
- Assert ctrl_reset mid-stream while a write to idx 12 = 0x1234, LFSR step and counter increment are all pending -> next cycle idx 12 = 0, idx 8 = 0x1, idx 9 = 0.
- Random write/read stream (10k cycles) against a reference model, for DATA_W=16, ADDR_W=4 and for the default parameters -> zero mismatches.
